// File: rtl/qpsk_modulator.sv
// qpsk_modulator
//
// Purpose:
//   Turns a serial bit stream into a QPSK waveform for an 8-bit DAC. Each
//   frame opens with PREAMBLE_SYMS sine-phase symbols. Data symbols follow
//   for as long as the next bit pair is ready in time. Every symbol lasts
//   32 samples and is read from a 32-entry sine table with a phase offset
//   chosen by the symbol value.
//
// Ports:
//   clk_fast   in   1  sample clock, rising edge
//   rst        in   1  asynchronous reset, active-low
//   start      in   1  single-cycle frame request, ignored while busy
//   bit_in     in   1  serial data bit
//   bit_valid  in   1  bit_in is valid this cycle
//   bit_ready  out  1  a bit can be accepted this cycle
//   wav_out    out  8  registered offset-binary DAC sample
//   busy       out  1  frame in progress (PREAMBLE or DATA)
//   sym_start  out  1  wav_out carries sample 0 of a symbol
//   frame_done out  1  one-cycle pulse in the first idle cycle after a frame

module qpsk_modulator #(
    parameter int          PREAMBLE_SYMS = 8,
    parameter logic [7:0]  IDLE_LEVEL    = 8'h40
) (
    input  logic       clk_fast,
    input  logic       rst,
    input  logic       start,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       bit_ready,
    output logic [7:0] wav_out,
    output logic       busy,
    output logic       sym_start,
    output logic       frame_done
);

    localparam int PRE_W = $clog2(PREAMBLE_SYMS + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_SYMS - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [4:0]       k, k_next;
    logic [PRE_W-1:0] pre_cnt, pre_cnt_next;
    logic [1:0]       cur_quad, cur_quad_next;

    logic             half_valid;
    logic             half_bit;
    logic             pending_full;
    logic [1:0]       pend_sym;
    logic             bit_accept;
    logic             pend_take;

    logic [7:0]       wav_next;
    logic             busy_next;
    logic             sym_start_next;
    logic             frame_done_next;

    function automatic logic [7:0] sine_lut(input logic [4:0] idx);
        logic [7:0] v;
        case (idx)
            5'd0:  v = 8'h40;  5'd1:  v = 8'h4c;  5'd2:  v = 8'h58;  5'd3:  v = 8'h64;
            5'd4:  v = 8'h6d;  5'd5:  v = 8'h75;  5'd6:  v = 8'h7b;  5'd7:  v = 8'h7f;
            5'd8:  v = 8'h80;  5'd9:  v = 8'h7f;  5'd10: v = 8'h7b;  5'd11: v = 8'h75;
            5'd12: v = 8'h6d;  5'd13: v = 8'h64;  5'd14: v = 8'h58;  5'd15: v = 8'h4c;
            5'd16: v = 8'h40;  5'd17: v = 8'h34;  5'd18: v = 8'h28;  5'd19: v = 8'h1c;
            5'd20: v = 8'h13;  5'd21: v = 8'h0b;  5'd22: v = 8'h05;  5'd23: v = 8'h01;
            5'd24: v = 8'h00;  5'd25: v = 8'h01;  5'd26: v = 8'h05;  5'd27: v = 8'h0b;
            5'd28: v = 8'h13;  5'd29: v = 8'h1c;  5'd30: v = 8'h28;  default: v = 8'h34;
        endcase
        return v;
    endfunction

    // The phase offset is a quarter-turn count (x8 samples). Gray-style
    // symbol order 00,01,11,10 maps onto quadrants 0,1,2,3.
    function automatic logic [1:0] sym_to_quad(input logic [1:0] s);
        return {s[1], s[1] ^ s[0]};
    endfunction

    assign bit_ready  = !pending_full;
    assign bit_accept = bit_valid && bit_ready;

    // State register
    always_ff @(posedge clk_fast or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            k        <= 5'd0;
            pre_cnt  <= '0;
            cur_quad <= 2'd0;
        end else begin
            state    <= state_next;
            k        <= k_next;
            pre_cnt  <= pre_cnt_next;
            cur_quad <= cur_quad_next;
        end
    end

    // Next-state logic. Symbol boundaries use the registered pending_full,
    // so a pair completing on the boundary edge waits for the next frame.
    always_comb begin
        state_next    = state;
        k_next        = k;
        pre_cnt_next  = pre_cnt;
        cur_quad_next = cur_quad;
        pend_take     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next    = PREAMBLE;
                    k_next        = 5'd0;
                    pre_cnt_next  = '0;
                    cur_quad_next = 2'd0;
                end
            end
            PREAMBLE: begin
                k_next = k + 5'd1;
                if (k == 5'd31) begin
                    if (pre_cnt == PRE_LAST) begin
                        if (pending_full) begin
                            state_next    = DATA;
                            cur_quad_next = sym_to_quad(pend_sym);
                            pend_take     = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        pre_cnt_next = pre_cnt + PRE_W'(1);
                    end
                end
            end
            DATA: begin
                k_next = k + 5'd1;
                if (k == 5'd31) begin
                    if (pending_full) begin
                        cur_quad_next = sym_to_quad(pend_sym);
                        pend_take     = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                k_next     = 5'd0;
            end
        endcase
    end

    // Output logic, computed from the next state so the outputs can be
    // registered and line up with the sample they describe.
    always_comb begin
        busy_next       = (state_next != IDLE);
        sym_start_next  = busy_next && (k_next == 5'd0);
        frame_done_next = (state != IDLE) && (state_next == IDLE);
        wav_next        = IDLE_LEVEL;
        if (busy_next) begin
            wav_next = sine_lut(k_next + {cur_quad_next, 3'b000});
        end
    end

    always_ff @(posedge clk_fast or negedge rst) begin
        if (!rst) begin
            wav_out    <= IDLE_LEVEL;
            busy       <= 1'b0;
            sym_start  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            wav_out    <= wav_next;
            busy       <= busy_next;
            sym_start  <= sym_start_next;
            frame_done <= frame_done_next;
        end
    end

    // Bit buffer. Accepting (needs !pending_full) and consuming (needs
    // pending_full) can never happen on the same edge. Contents survive
    // frame end; only rst clears them.
    always_ff @(posedge clk_fast or negedge rst) begin
        if (!rst) begin
            half_valid   <= 1'b0;
            half_bit     <= 1'b0;
            pending_full <= 1'b0;
            pend_sym     <= 2'b00;
        end else begin
            if (pend_take) begin
                pending_full <= 1'b0;
            end
            if (bit_accept) begin
                if (!half_valid) begin
                    half_bit   <= bit_in;
                    half_valid <= 1'b1;
                end else begin
                    pend_sym     <= {half_bit, bit_in};
                    pending_full <= 1'b1;
                    half_valid   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_qpsk_modulator.sv
// tb_qpsk_modulator
//
// Purpose:
//   Self-checking bench for qpsk_modulator. Stimulus pushes the expected
//   sample stream of each frame into a scoreboard queue; a monitor pops one
//   entry per busy cycle and checks idle behaviour and frame_done.
//
// Ports: none (top-level bench).

module tb_qpsk_modulator;

    localparam int         PRE  = 8;
    localparam logic [7:0] IDLE = 8'h40;

    logic       clk_fast = 1'b0;
    logic       rst      = 1'b0;
    logic       start    = 1'b0;
    logic       bit_in   = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_ready;
    logic [7:0] wav_out;
    logic       busy;
    logic       sym_start;
    logic       frame_done;

    qpsk_modulator #(
        .PREAMBLE_SYMS (PRE),
        .IDLE_LEVEL    (IDLE)
    ) dut (
        .clk_fast   (clk_fast),
        .rst        (rst),
        .start      (start),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .wav_out    (wav_out),
        .busy       (busy),
        .sym_start  (sym_start),
        .frame_done (frame_done)
    );

    always #5 clk_fast = ~clk_fast;

    typedef struct packed {
        logic [7:0] wav;
        logic       ss;
    } exp_t;

    typedef logic [1:0] sym_q_t[$];

    logic [7:0] sine_tbl [32] = '{
        8'h40, 8'h4c, 8'h58, 8'h64, 8'h6d, 8'h75, 8'h7b, 8'h7f,
        8'h80, 8'h7f, 8'h7b, 8'h75, 8'h6d, 8'h64, 8'h58, 8'h4c,
        8'h40, 8'h34, 8'h28, 8'h1c, 8'h13, 8'h0b, 8'h05, 8'h01,
        8'h00, 8'h01, 8'h05, 8'h0b, 8'h13, 8'h1c, 8'h28, 8'h34
    };

    // Phase offset in samples, indexed by symbol value 00,01,10,11.
    int off_of_sym [4] = '{0, 8, 24, 16};

    exp_t exp_q[$];
    exp_t e;
    int   vectors     = 0;
    int   miscompares = 0;
    int   abort_req   = 0;
    int   abort_ack   = 0;
    bit   mon_en      = 1'b0;
    bit   prev_busy   = 1'b0;

    task automatic report_fail(input string name, input int actual, input int expected);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic check_output(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: one scoreboard entry per busy cycle; idle cycles must sit at
    // IDLE and frame_done must mark exactly the first idle cycle of a
    // normally ending frame.
    always @(negedge clk_fast) begin
        if (mon_en) begin
            if (busy) begin
                if (exp_q.size() == 0) begin
                    report_fail("extra_sample", int'(wav_out), int'(IDLE));
                end else begin
                    e = exp_q.pop_front();
                    check_output("wav_sample", int'(wav_out), int'(e.wav));
                    check_output("sym_start", int'(sym_start), int'(e.ss));
                end
                check_output("frame_done_busy", int'(frame_done), 0);
            end else begin
                check_output("wav_idle", int'(wav_out), int'(IDLE));
                check_output("sym_start_idle", int'(sym_start), 0);
                if (prev_busy && (abort_req == abort_ack)) begin
                    check_output("frame_done_pulse", int'(frame_done), 1);
                    check_output("frame_length_left", exp_q.size(), 0);
                end else begin
                    check_output("frame_done_idle", int'(frame_done), 0);
                    if (prev_busy) begin
                        exp_q.delete();
                        abort_ack = abort_req;
                    end
                end
            end
        end
        prev_busy = busy;
    end

    task automatic tick();
        @(posedge clk_fast);
        #1;
    endtask

    task automatic push_symbol(input int off);
        exp_t x;
        for (int i = 0; i < 32; i++) begin
            x.wav = sine_tbl[(i + off) % 32];
            x.ss  = (i == 0);
            exp_q.push_back(x);
        end
    endtask

    task automatic push_preamble();
        for (int i = 0; i < PRE; i++) push_symbol(0);
    endtask

    // Offer one bit and hold it until an edge on which bit_ready was high.
    task automatic send_bit(input logic b);
        logic rdy;
        int   guard;
        bit_valid = 1'b1;
        bit_in    = b;
        guard     = 0;
        do begin
            rdy = bit_ready;
            tick();
            guard++;
        end while (!rdy && guard < 2000);
        if (!rdy) report_fail("bit_accept_timeout", 0, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_frame_end();
        int guard;
        guard = 0;
        while (busy && guard < 5000) begin
            tick();
            guard++;
        end
        if (busy) report_fail("frame_end_timeout", 1, 0);
        tick();
        tick();
    endtask

    // One frame: expected stream is the preamble followed by every symbol.
    // Bits are offered back to back so each pair is pending well before its
    // boundary.
    task automatic apply_stimulus(input sym_q_t syms, input bit preload);
        int first;
        push_preamble();
        foreach (syms[i]) push_symbol(off_of_sym[syms[i]]);
        first = 0;
        if (preload && syms.size() > 0) begin
            send_bit(syms[0][1]);
            send_bit(syms[0][0]);
            bit_valid = 1'b0;
            first = 1;
        end
        pulse_start();
        for (int i = first; i < syms.size(); i++) begin
            send_bit(syms[i][1]);
            send_bit(syms[i][0]);
        end
        bit_valid = 1'b0;
        wait_frame_end();
    endtask

    initial begin
        sym_q_t syms;
        int     n;

        // Reset state.
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check_output("reset_wav", int'(wav_out), int'(IDLE));
        check_output("reset_bit_ready", int'(bit_ready), 1);
        check_output("reset_busy", int'(busy), 0);
        check_output("reset_sym_start", int'(sym_start), 0);
        check_output("reset_frame_done", int'(frame_done), 0);
        mon_en = 1'b1;
        tick();

        // Preamble only.
        syms = {};
        apply_stimulus(syms, 1'b0);

        // Preloaded 01 gives one cosine symbol.
        syms = {2'b01};
        apply_stimulus(syms, 1'b1);

        // 11 then 10 streamed during the preamble.
        syms = {2'b11, 2'b10};
        apply_stimulus(syms, 1'b0);

        // bit_valid held high across a repeating 00 01 11 10 pattern.
        syms = {2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10};
        apply_stimulus(syms, 1'b0);

        // Randomised frames.
        for (int t = 0; t < 6; t++) begin
            syms = {};
            n = $urandom_range(0, 4);
            for (int i = 0; i < n; i++) syms.push_back(2'($urandom_range(0, 3)));
            apply_stimulus(syms, 1'($urandom_range(0, 1)));
        end

        // Pair completing on the final preamble edge stays for the next frame.
        push_preamble();
        send_bit(1'b1);
        bit_valid = 1'b0;
        pulse_start();
        repeat (255) tick();
        bit_valid = 1'b1;
        bit_in    = 1'b0;
        tick();
        bit_valid = 1'b0;
        wait_frame_end();
        check_output("pending_held_ready", int'(bit_ready), 0);
        push_preamble();
        push_symbol(off_of_sym[2'b10]);
        pulse_start();
        wait_frame_end();
        check_output("pending_used_ready", int'(bit_ready), 1);

        // A lone half bit survives a whole frame.
        send_bit(1'b1);
        bit_valid = 1'b0;
        push_preamble();
        pulse_start();
        wait_frame_end();
        send_bit(1'b1);
        bit_valid = 1'b0;
        push_preamble();
        push_symbol(off_of_sym[2'b11]);
        pulse_start();
        wait_frame_end();

        // Reset during DATA at k=13 aborts without frame_done.
        push_preamble();
        push_symbol(off_of_sym[2'b01]);
        send_bit(1'b0);
        send_bit(1'b1);
        bit_valid = 1'b0;
        pulse_start();
        repeat (269) tick();
        check_output("data_k13_wav", int'(wav_out), int'(sine_tbl[21]));
        abort_req++;
        rst = 1'b0;
        #1;
        check_output("abort_wav", int'(wav_out), int'(IDLE));
        check_output("abort_busy", int'(busy), 0);
        check_output("abort_frame_done", int'(frame_done), 0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        syms = {};
        apply_stimulus(syms, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got 0x1, expected 0x0");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
